// File: rtl/zjh_rep_tx.sv
// zjh_rep_tx: serial repetition-code transmitter.
// Accepts a DATA_W-bit word over valid/ready and sends it MSB first as a
// start symbol, the data symbols and an optional even-parity symbol, each
// held for REP cycles so the receiver can majority-vote every group.
// Optional feature macro: ZJH_REP_TX_PARITY_EN (adds the parity symbol).
module zjh_rep_tx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_out,
  output logic              tx_active,
  output logic              done
);

  localparam int unsigned REP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
`ifdef ZJH_REP_TX_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd3;
`endif

  logic [1:0]        state_q,     state_d;
  logic [REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
`ifdef ZJH_REP_TX_PARITY_EN
  logic              parity_q,    parity_d;
`endif
  logic              tx_out_q,    tx_out_d;
  logic              tx_active_q, tx_active_d;
  logic              done_q,      done_d;

  logic              sym_end;
  logic              last_bit;

  // Ready is a pure decode of the state register.
  assign din_ready = (state_q == ST_IDLE);

  assign sym_end  = (rep_cnt_q == REP_LAST);
  assign last_bit = (bit_cnt_q == BIT_LAST);

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef ZJH_REP_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (din_valid && din_ready) begin
          state_d   = ST_START;
          rep_cnt_d = '0;
          bit_cnt_d = '0;
          shift_d   = din;
`ifdef ZJH_REP_TX_PARITY_EN
          parity_d  = ^din;
`endif
        end
      end

      ST_START: begin
        if (sym_end) begin
          state_d   = ST_DATA;
          rep_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end

      ST_DATA: begin
        if (sym_end) begin
          rep_cnt_d = '0;
          shift_d   = shift_q << 1;
          if (last_bit) begin
            bit_cnt_d = '0;
`ifdef ZJH_REP_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end

`ifdef ZJH_REP_TX_PARITY_EN
      ST_PARITY: begin
        if (sym_end) begin
          state_d   = ST_IDLE;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
`endif

      default: begin
        state_d   = ST_IDLE;
        rep_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered line tracks the
  // state register with no extra cycle of latency.
  always_comb begin
    tx_out_d    = 1'b0;
    tx_active_d = (state_d != ST_IDLE);
    done_d      = 1'b0;

    case (state_d)
      ST_START: tx_out_d = 1'b1;
      ST_DATA:  tx_out_d = shift_d[DATA_W-1];
`ifdef ZJH_REP_TX_PARITY_EN
      ST_PARITY: tx_out_d = parity_d;
`endif
      default:  tx_out_d = 1'b0;
    endcase

`ifdef ZJH_REP_TX_PARITY_EN
    done_d = (state_d == ST_PARITY) && (rep_cnt_d == REP_LAST);
`else
    done_d = (state_d == ST_DATA) && (bit_cnt_d == BIT_LAST) &&
             (rep_cnt_d == REP_LAST);
`endif
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rep_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
`ifdef ZJH_REP_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      tx_out_q    <= 1'b0;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rep_cnt_q   <= rep_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
`ifdef ZJH_REP_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
      tx_out_q    <= tx_out_d;
      tx_active_q <= tx_active_d;
      done_q      <= done_d;
    end
  end

  assign tx_out    = tx_out_q;
  assign tx_active = tx_active_q;
  assign done      = done_q;

endmodule

// File: tb/tb_zjh_rep_tx.sv
// Testbench for zjh_rep_tx: random and directed frames checked against a
// symbol-level model of the frame. Build with +define+ZJH_REP_TX_PARITY_EN
// to exercise the parity variant.
module tb_zjh_rep_tx;

  localparam int DATA_W = 8;
  localparam int REP    = 3;
`ifdef ZJH_REP_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = (1 + DATA_W + P) * REP;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              tx_out;
  logic              tx_active;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  zjh_rep_tx #(.DATA_W(DATA_W), .REP(REP)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx_out    (tx_out),
    .tx_active (tx_active),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Line value for every cycle of a frame: bit i is frame cycle i+1.
  function automatic logic [F-1:0] exp_frame(input logic [DATA_W-1:0] w);
    logic sym [1 + DATA_W + P];
    logic [F-1:0] r;
    sym[0] = 1'b1;
    for (int j = 0; j < DATA_W; j++) sym[1 + j] = w[DATA_W - 1 - j];
`ifdef ZJH_REP_TX_PARITY_EN
    sym[1 + DATA_W] = ^w;
`endif
    for (int i = 0; i < F; i++) r[i] = sym[i / REP];
    return r;
  endfunction

  task automatic test_reset();
    logic [2:0] obs;
    rst = 1'b1;
    din_valid = 1'b1;
    din = DATA_W'($urandom);
    repeat (3) begin
      @(negedge clk);
      obs = {tx_out, tx_active, done};
      n_cmp++;
      if (obs !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold: got %b want 000 (tx_out,tx_active,done)", obs);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tx_out, tx_active, done, din_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_release: got %b want 0001", {tx_out, tx_active, done, din_ready});
    end
  endtask

  task automatic test_single_frame(input logic [DATA_W-1:0] w);
    logic [F-1:0] e;
    logic [3:0] obs, want;
    e = exp_frame(w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready w=%h: got %b want 1", w, din_ready);
    end
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      obs = {tx_out, tx_active, done, din_ready};
      want = {e[i], 1'b1, (i == F - 1), 1'b0};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL single_frame w=%h cyc=%0d: got %b want %b", w, i + 1, obs, want);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({tx_out, tx_active, done, din_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL single_after w=%h: got %b want 0001", w, {tx_out, tx_active, done, din_ready});
    end
  endtask

  task automatic test_random_frames();
    repeat (6) test_single_frame(DATA_W'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [F-1:0] e1, e2;
    logic [3:0] obs, want;
    int found;
    e1 = exp_frame(8'hFF);
    e2 = exp_frame(8'h00);
    found = 0;
    @(negedge clk);
    din = 8'hFF;
    din_valid = 1'b1;
    for (int c = 1; c <= 2 * F && found == 0; c++) begin
      @(negedge clk);
      if (c == 1) din = 8'h00;
      obs = {tx_out, tx_active, done, din_ready};
      if (c <= F) begin
        want = {e1[c - 1], 1'b1, (c == F), 1'b0};
        n_cmp++;
        if (obs !== want) begin
          n_err++;
          $display("FAIL b2b_frame1 cyc=%0d: got %b want %b", c, obs, want);
        end
      end else if (din_ready === 1'b1) begin
        found = c;
        n_cmp++;
        if (obs !== 4'b0001) begin
          n_err++;
          $display("FAIL b2b_gap cyc=%0d: got %b want 0001", c, obs);
        end
      end
    end
    n_cmp++;
    if (found != F + 1) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d want %0d", found, F + 1);
    end
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      obs = {tx_out, tx_active, done, din_ready};
      want = {e2[i], 1'b1, (i == F - 1), 1'b0};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL b2b_frame2 cyc=%0d: got %b want %b", i + 1, obs, want);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({tx_out, tx_active, done, din_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL b2b_after: got %b want 0001", {tx_out, tx_active, done, din_ready});
    end
  endtask

  task automatic test_busy_ignore();
    logic [DATA_W-1:0] w;
    logic [F-1:0] e;
    logic [3:0] obs, want;
    w = DATA_W'($urandom);
    e = exp_frame(w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      obs = {tx_out, tx_active, done, din_ready};
      want = {e[i], 1'b1, (i == F - 1), 1'b0};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL busy_frame w=%h cyc=%0d: got %b want %b", w, i + 1, obs, want);
      end
      din = DATA_W'($urandom);
      din_valid = (i < F - 1) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({tx_out, tx_active, done, din_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL busy_after: got %b want 0001", {tx_out, tx_active, done, din_ready});
    end
  endtask

  task automatic test_mid_reset();
    logic [DATA_W-1:0] w;
    logic [F-1:0] e;
    logic [3:0] obs, want;
    w = DATA_W'($urandom);
    e = exp_frame(w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      obs = {tx_out, tx_active, done, din_ready};
      want = {e[i], 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL midrst_pre cyc=%0d: got %b want %b", i + 1, obs, want);
      end
    end
    rst = 1'b1;
    for (int c = 11; c <= F + 2; c++) begin
      @(negedge clk);
      rst = 1'b0;
      obs = {tx_out, tx_active, done, din_ready};
      n_cmp++;
      if (obs !== 4'b0001) begin
        n_err++;
        $display("FAIL midrst_abort cyc=%0d: got %b want 0001", c, obs);
      end
    end
    w = DATA_W'($urandom);
    e = exp_frame(w);
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      obs = {tx_out, tx_active, done, din_ready};
      want = {e[i], 1'b1, (i == F - 1), 1'b0};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL midrst_next w=%h cyc=%0d: got %b want %b", w, i + 1, obs, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'h01);
    test_random_frames();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
